// File: rtl/rx_word_packer.sv
// ============================================================================
// rx_word_packer
//
// Sits between the UART receiver and the processing core. Pairs received
// bytes little-endian into 16-bit words, queues them in a small FIFO, and
// presents each word to the core as a fixed-width valid pulse followed by a
// mandatory low gap. The core detects words on the rising edge of
// data_in_valid, which is why the gap is never skipped.
//
// Ports:
//   clk            in   1   single clock, posedge
//   rst            in   1   asynchronous active-high reset
//   rx_byte        in   8   received byte
//   rx_byte_valid  in   1   one-cycle strobe qualifying rx_byte
//   rx_error       in   1   one-cycle framing-error strobe
//   core_busy      in   1   blocks presentation of a new word while high
//   data_in        out  16  word to the core, stable until the next pop
//   data_in_valid  out  1   word strobe (HOLD_CYCLES high, GAP_CYCLES low)
//   overflow       out  1   sticky: a completed word was dropped (FIFO full)
//   fifo_level     out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
// ============================================================================
module rx_word_packer #(
    parameter int FIFO_DEPTH  = 4,
    parameter int HOLD_CYCLES = 2,
    parameter int GAP_CYCLES  = 2,
    parameter int TIMEOUT     = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    rx_byte,
    input  logic                          rx_byte_valid,
    input  logic                          rx_error,
    input  logic                          core_busy,
    output logic [15:0]                   data_in,
    output logic                          data_in_valid,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int LVL_W    = PTR_W + 1;
    localparam int TO_W     = $clog2(TIMEOUT + 1);
    localparam int PACE_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int PACE_W   = $clog2(PACE_MAX + 1);

    // ------------------------------------------------------------------
    // Byte assembler
    // ------------------------------------------------------------------
    typedef enum logic {
        WAIT_LO,
        WAIT_HI
    } asm_state_t;

    asm_state_t       asm_state_reg;
    logic [7:0]       lo_reg;
    logic [TO_W-1:0]  to_cnt_reg;

    logic             push_req;
    logic [15:0]      push_word;

    // A framing error on the same cycle as a byte kills that byte as well.
    assign push_req  = (asm_state_reg == WAIT_HI) && rx_byte_valid && !rx_error;
    assign push_word = {rx_byte, lo_reg};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_state_reg <= WAIT_LO;
            lo_reg        <= 8'h00;
            to_cnt_reg    <= '0;
        end else if (rx_error) begin
            asm_state_reg <= WAIT_LO;
            lo_reg        <= 8'h00;
            to_cnt_reg    <= '0;
        end else begin
            case (asm_state_reg)
                WAIT_LO: begin
                    if (rx_byte_valid) begin
                        lo_reg        <= rx_byte;
                        to_cnt_reg    <= '0;
                        asm_state_reg <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    // The high byte is checked before the timeout, so a
                    // byte arriving on the expiry cycle still completes.
                    if (rx_byte_valid) begin
                        asm_state_reg <= WAIT_LO;
                    end else if (to_cnt_reg == TO_W'(TIMEOUT - 1)) begin
                        lo_reg        <= 8'h00;
                        asm_state_reg <= WAIT_LO;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + TO_W'(1);
                    end
                end
                default: asm_state_reg <= WAIT_LO;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Word FIFO
    // ------------------------------------------------------------------
    logic [15:0]       mem_reg [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [LVL_W-1:0]  level_reg;
    logic              overflow_reg;

    logic              fifo_empty;
    logic              fifo_full;
    logic              push_ok;
    logic              pop;

    assign fifo_empty = (level_reg == '0);
    assign fifo_full  = (level_reg == LVL_W'(FIFO_DEPTH));

    // A full FIFO still takes a word when the head leaves on the same edge.
    assign push_ok = push_req && (!fifo_full || pop);

    // Storage has no reset so it can map onto RAM; emptiness is tracked by
    // the pointers and level alone.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_reg[wr_ptr_reg] <= push_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            if (push_ok && !pop) begin
                level_reg <= level_reg + LVL_W'(1);
            end else if (!push_ok && pop) begin
                level_reg <= level_reg - LVL_W'(1);
            end
            if (push_req && !push_ok) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output pacing
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        GAP
    } out_state_t;

    out_state_t         out_state_reg;
    logic [PACE_W-1:0]  pace_cnt_reg;
    logic [15:0]        data_reg;
    logic               valid_reg;

    logic               pop_slot;

    // The last gap cycle doubles as the IDLE decision point so that
    // back-to-back words keep exactly GAP_CYCLES low clocks between pulses.
    assign pop_slot = (out_state_reg == IDLE) ||
                      ((out_state_reg == GAP) && (pace_cnt_reg == '0));
    assign pop      = pop_slot && !fifo_empty && !core_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_state_reg <= IDLE;
            pace_cnt_reg  <= '0;
            data_reg      <= 16'h0000;
            valid_reg     <= 1'b0;
        end else begin
            case (out_state_reg)
                IDLE: begin
                    if (pop) begin
                        // Simultaneous write to a full FIFO hits this same
                        // slot; the read returns the old head.
                        data_reg      <= mem_reg[rd_ptr_reg];
                        valid_reg     <= 1'b1;
                        pace_cnt_reg  <= PACE_W'(HOLD_CYCLES - 1);
                        out_state_reg <= HOLD;
                    end
                end
                HOLD: begin
                    if (pace_cnt_reg == '0) begin
                        valid_reg     <= 1'b0;
                        pace_cnt_reg  <= PACE_W'(GAP_CYCLES - 1);
                        out_state_reg <= GAP;
                    end else begin
                        pace_cnt_reg <= pace_cnt_reg - PACE_W'(1);
                    end
                end
                GAP: begin
                    if (pace_cnt_reg == '0) begin
                        if (pop) begin
                            data_reg      <= mem_reg[rd_ptr_reg];
                            valid_reg     <= 1'b1;
                            pace_cnt_reg  <= PACE_W'(HOLD_CYCLES - 1);
                            out_state_reg <= HOLD;
                        end else begin
                            out_state_reg <= IDLE;
                        end
                    end else begin
                        pace_cnt_reg <= pace_cnt_reg - PACE_W'(1);
                    end
                end
                default: begin
                    valid_reg     <= 1'b0;
                    out_state_reg <= IDLE;
                end
            endcase
        end
    end

    assign data_in       = data_reg;
    assign data_in_valid = valid_reg;
    assign overflow      = overflow_reg;
    assign fifo_level    = level_reg;

endmodule

// File: tb/tb_rx_word_packer.sv
// ============================================================================
// tb_rx_word_packer
//
// Bench for rx_word_packer at default parameters. Expected words are queued
// when their bytes are driven; a negedge monitor pops and compares them on
// each rising edge of data_in_valid and also checks pulse width, gap and
// (when enabled) the rise-to-rise period.
// ============================================================================
module tb_rx_word_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_byte;
    logic        rx_byte_valid;
    logic        rx_error;
    logic        core_busy;
    logic [15:0] data_in;
    logic        data_in_valid;
    logic        overflow;
    logic [2:0]  fifo_level;

    rx_word_packer dut (
        .clk           (clk),
        .rst           (rst),
        .rx_byte       (rx_byte),
        .rx_byte_valid (rx_byte_valid),
        .rx_error      (rx_error),
        .core_busy     (core_busy),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .overflow      (overflow),
        .fifo_level    (fifo_level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q[$];

    bit mon_en       = 1'b0;
    bit prev_valid   = 1'b0;
    bit have_fall    = 1'b0;
    bit have_rise    = 1'b0;
    bit check_period = 1'b0;
    int high_cnt     = 0;
    int fall_cyc     = 0;
    int rise_cyc     = 0;
    int rise_cnt     = 0;

    typedef struct {
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic mon_reset();
        prev_valid = data_in_valid;
        have_fall  = 1'b0;
        have_rise  = 1'b0;
        high_cnt   = 0;
    endtask

    // Output monitor / scoreboard consumer
    always @(negedge clk) begin
        logic [15:0] e;
        if (mon_en) begin
            if (data_in_valid && !prev_valid) begin
                rise_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word actual=%04h required=none", data_in);
                end else begin
                    e = exp_q.pop_front();
                    $display("word %04h presented at cycle %0d (expected %04h)", data_in, cyc, e);
                    check("word", data_in, e);
                end
                if (have_fall) begin
                    checks++;
                    if (cyc - fall_cyc < 2) begin
                        errors++;
                        $display("FAIL gap_len actual=%0d required>=2", cyc - fall_cyc);
                    end
                end
                if (check_period && have_rise) begin
                    check("period", cyc - rise_cyc, 4);
                end
                rise_cyc  = cyc;
                have_rise = 1'b1;
                high_cnt  = 0;
            end
            if (data_in_valid) high_cnt++;
            if (!data_in_valid && prev_valid) begin
                check("high_len", high_cnt, 2);
                fall_cyc  = cyc;
                have_fall = 1'b1;
            end
            prev_valid = data_in_valid;
        end
    end

    // All stimulus tasks start and end at a negedge.
    task automatic send_byte(input logic [7:0] b);
        rx_byte       = b;
        rx_byte_valid = 1'b1;
        @(negedge clk);
        rx_byte_valid = 1'b0;
    endtask

    task automatic pulse_error();
        rx_error = 1'b1;
        @(negedge clk);
        rx_error = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || fifo_level != 0 || data_in_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL drain_%s actual=%0d words pending required=0", name, exp_q.size());
            exp_q.delete();
        end
        idle(3);
    endtask

    task automatic wait_rise(input string name);
        int n;
        n = 0;
        while (!data_in_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(name, data_in_valid, 1);
    endtask

    initial begin
        int rc;

        vecs[0] = '{8'h01, 8'hA0, 16'hA001};
        vecs[1] = '{8'hFF, 8'h00, 16'h00FF};
        vecs[2] = '{8'h00, 8'hFF, 16'hFF00};
        vecs[3] = '{8'h5A, 8'hA5, 16'hA55A};
        vecs[4] = '{8'h80, 8'h7F, 16'h7F80};
        vecs[5] = '{8'hFF, 8'hFF, 16'hFFFF};

        rst           = 1'b1;
        rx_byte       = 8'h00;
        rx_byte_valid = 1'b0;
        rx_error      = 1'b0;
        core_busy     = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_data_in", data_in, 16'h0000);
        check("rst_valid", data_in_valid, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_level", fifo_level, 3'd0);
        rst = 1'b0;
        idle(2);
        mon_reset();
        mon_en = 1'b1;

        // Basic pairing with latency: high byte at N, pop at N+1
        send_byte(8'h34);
        rx_byte       = 8'h12;
        rx_byte_valid = 1'b1;
        exp_q.push_back(16'h1234);
        @(negedge clk);
        rx_byte_valid = 1'b0;
        check("basic_level_after_push", fifo_level, 3'd1);
        check("basic_valid_before_pop", data_in_valid, 1'b0);
        @(negedge clk);
        check("basic_valid_after_pop", data_in_valid, 1'b1);
        check("basic_data_in", data_in, 16'h1234);
        check("basic_level_after_pop", fifo_level, 3'd0);
        wait_drain("basic");

        // Table-driven pairs
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(vecs[i].exp);
            send_byte(vecs[i].lo);
            send_byte(vecs[i].hi);
            idle(2);
        end
        wait_drain("table");

        // Burst with core busy: six words, only four fit
        core_busy = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            send_byte(8'(i));
            send_byte(8'h00);
        end
        idle(1);
        check("burst_level_saturated", fifo_level, 3'd4);
        check("burst_overflow", overflow, 1'b1);
        for (int i = 1; i <= 4; i++) exp_q.push_back(16'(i));
        have_rise    = 1'b0;
        check_period = 1'b1;
        core_busy    = 1'b0;
        @(negedge clk);
        check("busy_release_latency", data_in_valid, 1'b1);
        wait_drain("burst");
        check_period = 1'b0;
        check("overflow_sticky", overflow, 1'b1);

        // Reset in HOLD with two words still queued
        core_busy = 1'b1;
        exp_q.push_back(16'hC1C0);
        send_byte(8'hC0); send_byte(8'hC1);
        send_byte(8'hC2); send_byte(8'hC3);
        send_byte(8'hC4); send_byte(8'hC5);
        check("rst_test_level3", fifo_level, 3'd3);
        core_busy = 1'b0;
        wait_rise("rst_test_rise");
        core_busy = 1'b1;
        check("rst_test_level2", fifo_level, 3'd2);
        mon_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", data_in_valid, 1'b0);
        check("async_rst_data_in", data_in, 16'h0000);
        check("async_rst_level", fifo_level, 3'd0);
        check("async_rst_overflow", overflow, 1'b0);
        @(negedge clk);
        rst       = 1'b0;
        core_busy = 1'b0;
        exp_q.delete();
        mon_reset();
        mon_en = 1'b1;
        rc = rise_cnt;
        idle(20);
        check("no_word_after_reset", rise_cnt - rc, 0);
        check("level_after_reset", fifo_level, 3'd0);

        // Framing error discards partial word
        send_byte(8'h11);
        pulse_error();
        exp_q.push_back(16'h3322);
        send_byte(8'h22);
        send_byte(8'h33);
        wait_drain("framing");
        // Error beats a simultaneous byte
        send_byte(8'h44);
        rx_byte       = 8'h55;
        rx_byte_valid = 1'b1;
        rx_error      = 1'b1;
        @(negedge clk);
        rx_byte_valid = 1'b0;
        rx_error      = 1'b0;
        exp_q.push_back(16'h7766);
        send_byte(8'h66);
        send_byte(8'h77);
        wait_drain("framing_priority");
        check("framing_no_overflow", overflow, 1'b0);

        // Busy asserted during a pulse
        core_busy = 1'b1;
        exp_q.push_back(16'hB001);
        exp_q.push_back(16'hB002);
        send_byte(8'h01); send_byte(8'hB0);
        send_byte(8'h02); send_byte(8'hB0);
        core_busy = 1'b0;
        wait_rise("busy_mid_rise");
        @(negedge clk);
        core_busy = 1'b1;
        rc = rise_cnt;
        idle(20);
        check("busy_holds_next_word", rise_cnt - rc, 0);
        check("busy_level", fifo_level, 3'd1);
        core_busy = 1'b0;
        wait_drain("busy_mid");

        // Timeout expired: low byte discarded, later pair forms the word
        exp_q.push_back(16'h5678);
        send_byte(8'hAA);
        idle(1029);
        send_byte(8'h78);
        check("timeout_expired_nopush", fifo_level, 3'd0);
        send_byte(8'h56);
        wait_drain("timeout_expired");

        // High byte inside the timeout window completes the word
        exp_q.push_back(16'h78AA);
        send_byte(8'hAA);
        idle(1022);
        send_byte(8'h78);
        check("timeout_window_push", fifo_level, 3'd1);
        wait_drain("timeout_window");

        check("final_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
